eight_bit_div_seq: RTL and testbench
====================================

Name: eight_bit_div_seq

Overview:
Sequential restoring divider built on the same subtract path as the team's 8-bit arithmetic unit. Where the AU produces sums and differences in one pass, this block iterates one subtraction per clock to compute quotient and remainder. It sits beside the AU as the multi-cycle divide resource. Handshake is start/busy/done, with Z and divide-by-zero flags in the AU style.

Parameters:
WIDTH, 8, operand, quotient and remainder width. The iteration count equals WIDTH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when ready to accept (IDLE or DONE).
A  input  WIDTH  dividend, unsigned.
B  input  WIDTH  divisor, unsigned.
Q  output  WIDTH  quotient; registered.
R  output  WIDTH  remainder; registered.
busy  output  1  high while iterating.
done  output  1  one-cycle pulse; Q and R are valid.
Z  output  1  high when Q == 0; valid with done and held afterwards.
dbz  output  1  divide-by-zero flag; valid with done and held afterwards.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, Q=0, R=0, busy=0, done=0, Z=0, dbz=0, iteration counter=0. Reset overrides everything, including mid-run; no partial result is ever reported.
- States: IDLE, RUN, DONE.
- Accept rule: start=1 in IDLE or DONE latches A and B into internal registers at that edge.
  - If B != 0: partial remainder (WIDTH+1 bits) <= 0, quotient shift register <= A, counter <= 0, state -> RUN, busy=1.
  - If B == 0: state -> DONE directly, Q=all ones, R=A, dbz=1, Z=0.
- start in RUN is ignored. The latched operands are unaffected; later changes on A and B have no effect.
- RUN, one iteration per edge:
  - rem <= {rem[WIDTH-1:0], qreg[WIDTH-1]}; qreg shifts left.
  - trial = rem - {1'b0, B}, computed WIDTH+1 bits wide.
  - If trial is non-negative (no borrow): rem <= trial and the new qreg LSB = 1. Otherwise rem is unchanged and the LSB = 0.
  - The counter increments. After the WIDTH-th iteration: state -> DONE.
- DONE entry edge: Q <= qreg, R <= rem[WIDTH-1:0], Z <= (qreg == 0), dbz <= 0, busy=0, done=1 for exactly that cycle.
- Latency: start accepted at edge k. Done is visible after edge k+WIDTH (8 cycles for the default), or after edge k for B == 0.
- DONE lasts one cycle, then returns to IDLE. If start=1 during the DONE cycle, a new operation is accepted at that edge (back-to-back, no dead cycle).
- Q, R, Z and dbz hold their values until the next completion or reset.
- Invariants checked by the bench whenever done=1 and dbz=0: A == Q*B + R and R < B.

Test Plan:
- A=200, B=7, start for 1 cycle -> busy for 8 cycles; done pulse after edge k+8; Q=28, R=4, Z=0, dbz=0.
- A=5, B=9 -> Q=0, R=5, Z=1. Then A=255, B=1 -> Q=255, R=0, Z=0.
- A=0x3C, B=0 -> done after 1 edge; dbz=1, Q=0xFF, R=0x3C, busy never asserted.
- Start A=100, B=3; pulse start again with A=9, B=9 at cycle 4 -> second request ignored; result Q=33, R=1.
- Start A=250, B=10; assert rst at cycle 5 -> next cycle busy=0, done=0, Q=0, R=0, state IDLE; then A=250, B=10 -> Q=25, R=0.
- Back-to-back: hold start=1 in the DONE cycle with a new A=17, B=4 -> second done exactly 8 cycles later; Q=4, R=1. Then exhaustive or random 8-bit pairs against a reference model.

Source files
------------

// File: rtl/eight_bit_div_seq.sv
// Sequential restoring divider: one trial subtraction per clock, WIDTH iterations.
// Start/busy/done handshake with quotient-zero and divide-by-zero flags.
module eight_bit_div_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             Z,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             z_q, z_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             last_iter;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  assign accept    = start && (state_q != S_RUN);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = (B == '0) ? S_DONE : S_RUN;
        else        state_d = S_IDLE;
      end
      S_RUN: if (last_iter) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    Q    = q_q;
    R    = r_q;
    Z    = z_q;
    dbz  = dbz_q;
  end

  // Trial subtraction is one bit wider than the remainder so the MSB is the borrow.
  always_comb begin
    shifted = {rem_q, qreg_q[WIDTH-1]};
    trial   = shifted - {2'b00, b_q};
    borrow  = trial[WIDTH+1];
  end

  always_comb begin
    rem_d  = rem_q;
    qreg_d = qreg_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    z_d    = z_q;
    dbz_d  = dbz_q;
    if (accept) begin
      b_d = B;
      if (B == '0) begin
        q_d   = '1;
        r_d   = A;
        z_d   = 1'b0;
        dbz_d = 1'b1;
      end else begin
        rem_d  = '0;
        qreg_d = A;
        cnt_d  = '0;
      end
    end else if (state_q == S_RUN) begin
      rem_d  = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
      qreg_d = {qreg_q[WIDTH-2:0], ~borrow};
      cnt_d  = cnt_q + CW'(1);
      // Results are taken from this iteration's next values so done needs no extra cycle.
      if (last_iter) begin
        q_d   = qreg_d;
        r_d   = rem_d[WIDTH-1:0];
        z_d   = (qreg_d == '0);
        dbz_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      qreg_q <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      z_q    <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      qreg_q <= qreg_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      r_q    <= r_d;
      z_q    <= z_d;
      dbz_q  <= dbz_d;
    end
  end

endmodule

// File: tb/tb_eight_bit_div_seq.sv
// Self-checking bench for eight_bit_div_seq: directed scenarios plus random
// operand pairs compared against plain integer division.
module tb_eight_bit_div_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [7:0] Q, R;
  logic       busy, done, Z, dbz;

  int checks = 0;
  int errors = 0;

  eight_bit_div_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .Z(Z), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Reference: quotient/remainder/flags from plain arithmetic.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int z, output int dz);
    if (b == 0) begin
      q = 255; r = a; z = 0; dz = 1;
    end else begin
      q = a / b; r = a % b; z = (q == 0) ? 1 : 0; dz = 0;
    end
  endfunction

  // Presents operands with start for one edge; returns sampled #1 after that edge.
  task automatic start_op(input int a, input int b);
    @(negedge clk);
    A = 8'(a); B = 8'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges (starting from the current sample) until done; bounded.
  task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    ok = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (Q !== 8'd0)  begin errors++; $display("FAIL reset_Q got %0d exp 0", Q); end
    checks++; if (R !== 8'd0)  begin errors++; $display("FAIL reset_R got %0d exp 0", R); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (Z !== 1'b0)  begin errors++; $display("FAIL reset_Z got %b exp 0", Z); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", dbz); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_result(input string name, input int a, input int b);
    int q, r, z, dz;
    model(a, b, q, r, z, dz);
    checks++; if (Q !== 8'(q)) begin errors++; $display("FAIL %s_Q a=%0d b=%0d got %0d exp %0d", name, a, b, Q, q); end
    checks++; if (R !== 8'(r)) begin errors++; $display("FAIL %s_R a=%0d b=%0d got %0d exp %0d", name, a, b, R, r); end
    checks++; if (Z !== 1'(z)) begin errors++; $display("FAIL %s_Z a=%0d b=%0d got %b exp %0d", name, a, b, Z, z); end
    checks++; if (dbz !== 1'(dz)) begin errors++; $display("FAIL %s_dbz a=%0d b=%0d got %b exp %0d", name, a, b, dbz, dz); end
    if (dz == 0) begin
      checks++;
      if ((int'(Q) * b + int'(R) != a) || (int'(R) >= b)) begin
        errors++; $display("FAIL %s_invariant a=%0d b=%0d got Q=%0d R=%0d", name, a, b, Q, R);
      end
    end
  endtask

  task automatic test_basic;
    int lat, bc; bit ok;
    start_op(200, 7);
    wait_done(lat, bc, ok);
    checks++; if (!ok)     begin errors++; $display("FAIL basic_timeout got done=0 exp 1"); end
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
    checks++; if (bc != 8)  begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bc); end
    check_result("basic", 200, 7);
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    checks++; if (Q !== 8'd28)   begin errors++; $display("FAIL basic_Q_hold got %0d exp 28", Q); end
  endtask

  task automatic test_zero_quotient;
    int lat, bc; bit ok;
    start_op(5, 9);
    wait_done(lat, bc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zq_timeout got done=0 exp 1"); end
    check_result("zq", 5, 9);
    start_op(255, 1);
    wait_done(lat, bc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL max_timeout got done=0 exp 1"); end
    check_result("max", 255, 1);
  endtask

  task automatic test_dbz;
    int lat, bc; bit ok;
    start_op(8'h3C, 0);
    wait_done(lat, bc, ok);
    checks++; if (!ok)      begin errors++; $display("FAIL dbz_timeout got done=0 exp 1"); end
    checks++; if (lat != 0) begin errors++; $display("FAIL dbz_latency got %0d exp 0", lat); end
    checks++; if (busy !== 1'b0 || bc != 0) begin errors++; $display("FAIL dbz_busy got %0d exp 0", bc); end
    check_result("dbz", 8'h3C, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dbz !== 1'b1 || Q !== 8'hFF) begin errors++; $display("FAIL dbz_hold got dbz=%b Q=%0d exp 1 255", dbz, Q); end
  endtask

  task automatic test_ignore_start;
    int lat, bc; bit ok;
    start_op(100, 3);
    repeat (3) @(posedge clk);
    start_op(9, 9);
    wait_done(lat, bc, ok);
    checks++; if (!ok)          begin errors++; $display("FAIL ign_timeout got done=0 exp 1"); end
    checks++; if (lat + 4 != 8) begin errors++; $display("FAIL ign_latency got %0d exp 8", lat + 4); end
    checks++; if (Q !== 8'd33 || R !== 8'd1) begin errors++; $display("FAIL ign_result got Q=%0d R=%0d exp 33 1", Q, R); end
  endtask

  task automatic test_reset_mid;
    int lat, bc; bit ok; int seen;
    start_op(250, 10);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (Q !== 8'd0 || R !== 8'd0) begin errors++; $display("FAIL rmid_out got Q=%0d R=%0d exp 0 0", Q, R); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_stale got %0d exp 0", seen); end
    start_op(250, 10);
    wait_done(lat, bc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout got done=0 exp 1"); end
    check_result("rmid", 250, 10);
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit ok;
    start_op(100, 7);
    wait_done(lat, bc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout got done=0 exp 1"); end
    start_op(17, 4);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b done=%b exp 1 0", busy, done); end
    wait_done(lat, bc, ok);
    checks++; if (!ok)      begin errors++; $display("FAIL b2b_timeout got done=0 exp 1"); end
    checks++; if (lat != 8) begin errors++; $display("FAIL b2b_latency got %0d exp 8", lat); end
    check_result("b2b", 17, 4);
  endtask

  task automatic test_random;
    int lat, bc; bit ok; int a, b;
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 25 == 0) ? 0 : int'($urandom_range(0, 255));
      start_op(a, b);
      wait_done(lat, bc, ok);
      checks++;
      if (!ok || lat != ((b == 0) ? 0 : 8)) begin
        errors++; $display("FAIL rand_latency a=%0d b=%0d got %0d exp %0d", a, b, lat, (b == 0) ? 0 : 8);
      end
      check_result("rand", a, b);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_quotient;
    test_dbz;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
